cache_refill_ctrl: RTL and testbench

- Miss handler and fill writer for the 32-entry direct-mapped, word-granular instruction/data cache.
- Watches the CPU lookup (address plus cache hit flag) and, on a miss, fetches the word from backing memory over a req/ack interface.
- Drives the cache fill write port (wen/waddr/wdata) and stalls the CPU until the refilled word hits.
- Adds a per-request timeout with bounded retry and a fault flag.

---
 rtl/cache_refill_ctrl.sv | 157 +++++++++++++++
 tb/tb_cache_refill_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/cache_refill_ctrl.sv
// cache_refill_ctrl
//
// Miss handler and fill writer for the 32-entry direct-mapped, word-granular
// cache. On a lookup miss it latches the address and reads the word from
// backing memory over a level req / pulse ack handshake. Each attempt has a
// TIMEOUT-cycle window; a timed-out attempt is followed by a one-cycle backoff
// and a retry, up to RETRIES extra attempts, after which a one-cycle fault
// pulse is raised. A successful read is written into the cache through the
// fill port, and the CPU is stalled until the refilled word hits.
//
// Ports:
//   clk          clock, all state changes on the rising edge
//   rst          synchronous reset, active-low
//   i_req        CPU lookup valid this cycle
//   i_addr       CPU lookup address, held stable while o_stall is high
//   i_hit        cache hit flag for i_addr
//   o_stall      CPU must hold the lookup and retry
//   o_mem_req    memory read request (level)
//   o_mem_addr   word-aligned memory read address
//   i_mem_ack    memory ack pulse, i_mem_rdata valid in the same cycle
//   i_mem_rdata  memory read data
//   o_fill_wen   cache fill write enable (one-cycle pulse)
//   o_fill_addr  fill address (latched miss address)
//   o_fill_data  fill data (captured read data)
//   o_err        one-cycle fault pulse once every attempt has timed out
//   o_miss_cnt   count of completed refills, wraps
module cache_refill_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int RETRIES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  input  logic        i_hit,
  output logic        o_stall,
  output logic        o_mem_req,
  output logic [31:0] o_mem_addr,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_rdata,
  output logic        o_fill_wen,
  output logic [31:0] o_fill_addr,
  output logic [31:0] o_fill_data,
  output logic        o_err,
  output logic [31:0] o_miss_cnt
);

  // The timeout counter only needs to reach TIMEOUT-1; the retry counter
  // needs at least one bit even when no retries are configured.
  localparam int TW = $clog2(TIMEOUT);
  localparam int RW = (RETRIES < 1) ? 1 : $clog2(RETRIES + 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(RETRIES);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    BACKOFF,
    FILL,
    ERR
  } state_t;

  state_t        state;
  logic [TW-1:0] to_cnt;
  logic [RW-1:0] retry_cnt;
  logic [31:0]   addr_q;
  logic [31:0]   data_q;

  // Main controller. The pulse/level outputs are registered and are set on the
  // transition into the state that owns them, so o_mem_req is high exactly
  // while in REQ, o_fill_wen exactly in FILL and o_err exactly in ERR.
  // Memory acks are only looked at in REQ; everywhere else they fall through.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      to_cnt     <= '0;
      retry_cnt  <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      o_miss_cnt <= '0;
      o_mem_req  <= 1'b0;
      o_fill_wen <= 1'b0;
      o_err      <= 1'b0;
    end else begin
      o_fill_wen <= 1'b0;
      o_err      <= 1'b0;
      case (state)
        IDLE: begin
          if (i_req && !i_hit) begin
            addr_q    <= i_addr;
            to_cnt    <= '0;
            retry_cnt <= '0;
            o_mem_req <= 1'b1;
            state     <= REQ;
          end
        end
        REQ: begin
          // An ack arriving in the last cycle of the window still wins.
          if (i_mem_ack) begin
            data_q     <= i_mem_rdata;
            o_mem_req  <= 1'b0;
            o_fill_wen <= 1'b1;
            state      <= FILL;
          end else if (to_cnt == TO_LAST) begin
            o_mem_req <= 1'b0;
            if (retry_cnt < RETRY_MAX) begin
              retry_cnt <= retry_cnt + 1'b1;
              to_cnt    <= '0;
              state     <= BACKOFF;
            end else begin
              o_err <= 1'b1;
              state <= ERR;
            end
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        BACKOFF: begin
          o_mem_req <= 1'b1;
          state     <= REQ;
        end
        FILL: begin
          // The cache write lands at the end of this cycle, so the CPU sees a
          // hit on the next IDLE cycle.
          o_miss_cnt <= o_miss_cnt + 32'd1;
          state      <= IDLE;
        end
        ERR: begin
          state <= IDLE;
        end
        default: begin
          o_mem_req <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

  // Stall is combinational so a miss holds the CPU in the very cycle it is
  // seen; the fault cycle releases the CPU so it can take the access fault.
  always_comb begin
    o_stall = 1'b0;
    case (state)
      IDLE:    o_stall = i_req & ~i_hit;
      REQ:     o_stall = 1'b1;
      BACKOFF: o_stall = 1'b1;
      FILL:    o_stall = 1'b1;
      ERR:     o_stall = 1'b0;
      default: o_stall = 1'b0;
    endcase
  end

  assign o_mem_addr  = {addr_q[31:2], 2'b00};
  assign o_fill_addr = addr_q;
  assign o_fill_data = data_q;

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// tb_cache_refill_ctrl
//
// Directed bench for cache_refill_ctrl. Inputs are driven 1 time unit after
// each rising edge and outputs are sampled on the falling edge. Expected fills
// are pushed to a scoreboard queue when a miss is presented and popped by a
// monitor whenever the controller pulses o_fill_wen.
module tb_cache_refill_ctrl;

  localparam int TIMEOUT = 16;
  localparam int RETRIES = 2;

  logic        clk;
  logic        rst;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_hit;
  logic        o_stall;
  logic        o_mem_req;
  logic [31:0] o_mem_addr;
  logic        i_mem_ack;
  logic [31:0] i_mem_rdata;
  logic        o_fill_wen;
  logic [31:0] o_fill_addr;
  logic [31:0] o_fill_data;
  logic        o_err;
  logic [31:0] o_miss_cnt;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } fill_t;

  fill_t       sb[$];
  int          tests_run = 0;
  int          fail_cnt  = 0;
  logic [31:0] exp_miss  = 32'd0;

  cache_refill_ctrl #(
    .TIMEOUT(TIMEOUT),
    .RETRIES(RETRIES)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i_req      (i_req),
    .i_addr     (i_addr),
    .i_hit      (i_hit),
    .o_stall    (o_stall),
    .o_mem_req  (o_mem_req),
    .o_mem_addr (o_mem_addr),
    .i_mem_ack  (i_mem_ack),
    .i_mem_rdata(i_mem_rdata),
    .o_fill_wen (o_fill_wen),
    .o_fill_addr(o_fill_addr),
    .o_fill_data(o_fill_data),
    .o_err      (o_err),
    .o_miss_cnt (o_miss_cnt)
  );

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: counted always, failure counted and reported.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp)
    else begin
      fail_cnt++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drives one cycle of inputs just after the rising edge and returns at the
  // falling edge, where that cycle's outputs are stable.
  task automatic applyStimulus(input logic rst_v, input logic req, input logic [31:0] addr,
                               input logic hit, input logic ack, input logic [31:0] rdata);
    @(posedge clk);
    #1;
    rst         = rst_v;
    i_req       = req;
    i_addr      = addr;
    i_hit       = hit;
    i_mem_ack   = ack;
    i_mem_rdata = rdata;
    @(negedge clk);
  endtask

  // Every fill pulse must match the oldest outstanding expected fill.
  always @(negedge clk) begin
    if (o_fill_wen === 1'b1) begin
      checkOutput("fill_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        fill_t f;
        f = sb.pop_front();
        checkOutput("fill_addr", o_fill_addr, f.addr);
        checkOutput("fill_data", o_fill_data, f.data);
      end
    end
  end

  // Presents a miss and answers it. ack_win selects the request window
  // (0 = first attempt) and ack_pos the cycle within it (1..TIMEOUT) that
  // acks; an ack_win beyond RETRIES means memory never answers.
  task automatic runMiss(input logic [31:0] addr, input logic [31:0] data,
                         input int ack_win, input int ack_pos);
    logic done;
    logic ack;
    done = 1'b0;
    if (ack_win <= RETRIES) sb.push_back('{addr: addr, data: data});
    applyStimulus(1'b1, 1'b1, addr, 1'b0, 1'b0, 32'h0);
    checkOutput("miss_stall", o_stall, 1'b1);
    checkOutput("miss_req_low", o_mem_req, 1'b0);
    for (int w = 0; w <= RETRIES; w++) begin
      if (!done) begin
        if (w > 0) begin
          applyStimulus(1'b1, 1'b1, addr, 1'b0, 1'b0, 32'h0);
          checkOutput("backoff_req", o_mem_req, 1'b0);
          checkOutput("backoff_stall", o_stall, 1'b1);
        end
        for (int c = 1; c <= TIMEOUT; c++) begin
          if (!done) begin
            ack = (w == ack_win) && (c == ack_pos);
            applyStimulus(1'b1, 1'b1, addr, 1'b0, ack, ack ? data : 32'h0BAD_F00D);
            checkOutput("req_level", o_mem_req, 1'b1);
            checkOutput("req_addr", o_mem_addr, addr & 32'hFFFF_FFFC);
            checkOutput("req_stall", o_stall, 1'b1);
            checkOutput("req_no_err", o_err, 1'b0);
            if (ack) done = 1'b1;
          end
        end
      end
    end
    if (done) begin
      applyStimulus(1'b1, 1'b1, addr, 1'b0, 1'b0, 32'h0);
      checkOutput("fill_wen", o_fill_wen, 1'b1);
      checkOutput("fill_stall", o_stall, 1'b1);
      checkOutput("fill_req_low", o_mem_req, 1'b0);
      exp_miss = exp_miss + 32'd1;
      applyStimulus(1'b1, 1'b1, addr, 1'b1, 1'b0, 32'h0);
      checkOutput("hit_stall", o_stall, 1'b0);
      checkOutput("hit_wen", o_fill_wen, 1'b0);
      checkOutput("miss_cnt", o_miss_cnt, exp_miss);
    end else begin
      applyStimulus(1'b1, 1'b1, addr, 1'b0, 1'b0, 32'h0);
      checkOutput("err_pulse", o_err, 1'b1);
      checkOutput("err_stall", o_stall, 1'b0);
      checkOutput("err_req", o_mem_req, 1'b0);
      checkOutput("err_wen", o_fill_wen, 1'b0);
      applyStimulus(1'b1, 1'b0, addr, 1'b0, 1'b0, 32'h0);
      checkOutput("err_once", o_err, 1'b0);
      checkOutput("err_idle_stall", o_stall, 1'b0);
      checkOutput("err_miss_cnt", o_miss_cnt, exp_miss);
    end
  endtask

  initial begin
    rst         = 1'b0;
    i_req       = 1'b1;
    i_addr      = 32'h0000_0ABE;
    i_hit       = 1'b0;
    i_mem_ack   = 1'b0;
    i_mem_rdata = 32'h0;

    // Reset held with a pending miss: nothing may start.
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, 1'b1, 32'h0000_0ABE, 1'b0, 1'b0, 32'h0);
      checkOutput("rst_req", o_mem_req, 1'b0);
      checkOutput("rst_wen", o_fill_wen, 1'b0);
      checkOutput("rst_err", o_err, 1'b0);
      checkOutput("rst_cnt", o_miss_cnt, 32'd0);
    end
    // The miss is taken on the first edge with reset released.
    runMiss(32'h0000_0ABE, 32'h1111_2222, 0, 3);

    // Miss with single-cycle ack latency.
    runMiss(32'h0000_1234, 32'hDEAD_BEEF, 0, 1);

    // Hit path.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 1'b1, 32'h0000_0100 + 32'(i * 4), 1'b1, 1'b0, 32'h0);
      checkOutput("hit_path_stall", o_stall, 1'b0);
      checkOutput("hit_path_req", o_mem_req, 1'b0);
    end

    // One timeout, then ack on the 5th cycle of the retry window.
    runMiss(32'h8000_0042, 32'hCAFE_0001, 1, 5);

    // Memory never answers: three windows then a fault.
    runMiss(32'h0000_7FF0, 32'h0, RETRIES + 1, 1);

    // Ack on the last cycle of the first window wins over the timeout.
    runMiss(32'h0000_2000, 32'hA5A5_5A5A, 0, TIMEOUT);

    // Spurious acks while idle are ignored.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'hFFFF_0000);
      checkOutput("spur_req", o_mem_req, 1'b0);
      checkOutput("spur_wen", o_fill_wen, 1'b0);
      checkOutput("spur_stall", o_stall, 1'b0);
      checkOutput("spur_cnt", o_miss_cnt, exp_miss);
    end

    // Reset in the middle of a request: abandoned without fill or fault.
    applyStimulus(1'b1, 1'b1, 32'h0000_3330, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b1, 32'h0000_3330, 1'b0, 1'b0, 32'h0);
      checkOutput("pre_rst_req", o_mem_req, 1'b1);
    end
    applyStimulus(1'b0, 1'b1, 32'h0000_3330, 1'b0, 1'b0, 32'h0);
    exp_miss = 32'd0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, 32'h0000_3330, 1'b0, (i == 0), 32'h7777_7777);
      checkOutput("midrst_req", o_mem_req, 1'b0);
      checkOutput("midrst_wen", o_fill_wen, 1'b0);
      checkOutput("midrst_err", o_err, 1'b0);
      checkOutput("midrst_stall", o_stall, 1'b0);
      checkOutput("midrst_cnt", o_miss_cnt, exp_miss);
    end

    checkOutput("sb_drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
    $finish;
  end

endmodule
